// File: rtl/ex_mem_stage_pkg.sv
// Shared constants and types for the EX/MEM boundary: branch condition codes,
// the PC increment used for link addresses, and the registered control bundle.
package ex_mem_stage_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam int unsigned PC_INC = 4;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } mem_ctrl_t;

endpackage

// File: rtl/ex_mem_stage_branch_cond.sv
// Combinational branch condition evaluator: funct3 plus ALU flags -> taken.
// BLTU/BGEU follow the ALU's carry convention (cf=1 means no borrow).
module ex_mem_stage_branch_cond
  import ex_mem_stage_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       cf_i,
  input  logic       zf_i,
  input  logic       vf_i,
  input  logic       sf_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      BR_BEQ:  taken_o = zf_i;
      BR_BNE:  taken_o = ~zf_i;
      BR_BLT:  taken_o = sf_i ^ vf_i;
      BR_BGE:  taken_o = ~(sf_i ^ vf_i);
      BR_BLTU: taken_o = ~cf_i;
      BR_BGEU: taken_o = cf_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/jump resolution and a one-cycle redirect.
// Optional branch statistics counters are enabled by defining EXMEM_BR_STATS_EN.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int N    = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [N-1:0]    ex_pc,
  input  logic [N-1:0]    ex_imm,
  input  logic [N-1:0]    ex_alu_result,
  input  logic            ex_cf,
  input  logic            ex_zf,
  input  logic            ex_vf,
  input  logic            ex_sf,
  input  logic [N-1:0]    ex_rs2_data,
  input  logic [RD_W-1:0] ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_mem_to_reg,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic [2:0]      ex_funct3,
  output logic            mem_valid,
  output logic [N-1:0]    mem_alu_result,
  output logic [N-1:0]    mem_rs2_data,
  output logic [RD_W-1:0] mem_rd,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            mem_mem_to_reg,
  output logic            redirect,
  output logic [N-1:0]    redirect_target
`ifdef EXMEM_BR_STATS_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     br_taken_count
`endif
);

  localparam logic [N-1:0] PC_INC_N = N'(PC_INC);

  logic            valid_q, valid_d;
  logic [N-1:0]    result_q, result_d;
  logic [N-1:0]    rs2_q, rs2_d;
  logic [RD_W-1:0] rd_q, rd_d;
  mem_ctrl_t       ctrl_q, ctrl_d;
  logic            redirect_q, redirect_d;
  logic [N-1:0]    target_q, target_d;
  logic            taken;
  logic            load;

  ex_mem_stage_branch_cond u_branch_cond (
    .funct3_i (ex_funct3),
    .cf_i     (ex_cf),
    .zf_i     (ex_zf),
    .vf_i     (ex_vf),
    .sf_i     (ex_sf),
    .taken_o  (taken)
  );

  assign load = ~flush & ~stall;

  always_comb begin
    valid_d    = valid_q;
    result_d   = result_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    redirect_d = redirect_q;
    target_d   = target_q;
    if (flush) begin
      // Bubble: data fields keep stale values, only validity and controls clear.
      valid_d    = 1'b0;
      ctrl_d     = '0;
      redirect_d = 1'b0;
    end else if (stall) begin
      redirect_d = 1'b0;
    end else begin
      valid_d              = ex_valid;
      result_d             = (ex_jal | ex_jalr) ? ex_pc + PC_INC_N : ex_alu_result;
      rs2_d                = ex_rs2_data;
      rd_d                 = ex_rd;
      ctrl_d.reg_write     = ex_reg_write  & ex_valid;
      ctrl_d.mem_read      = ex_mem_read   & ex_valid;
      ctrl_d.mem_write     = ex_mem_write  & ex_valid;
      ctrl_d.mem_to_reg    = ex_mem_to_reg & ex_valid;
      // jalr > jal > branch when more than one is asserted.
      if (ex_jalr) begin
        redirect_d = ex_valid;
        target_d   = ex_alu_result & ~N'(1);
      end else if (ex_jal) begin
        redirect_d = ex_valid;
        target_d   = ex_pc + ex_imm;
      end else if (ex_branch) begin
        redirect_d = ex_valid & taken;
        target_d   = ex_pc + ex_imm;
      end else begin
        redirect_d = 1'b0;
        target_d   = ex_pc + ex_imm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
    end
  end

  assign mem_valid       = valid_q;
  assign mem_alu_result  = result_q;
  assign mem_rs2_data    = rs2_q;
  assign mem_rd          = rd_q;
  assign mem_reg_write   = ctrl_q.reg_write;
  assign mem_mem_read    = ctrl_q.mem_read;
  assign mem_mem_write   = ctrl_q.mem_write;
  assign mem_mem_to_reg  = ctrl_q.mem_to_reg;
  assign redirect        = redirect_q;
  assign redirect_target = target_q;

`ifdef EXMEM_BR_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] br_taken_q, br_taken_d;
  logic        is_ctl;

  assign is_ctl = ex_valid & (ex_branch | ex_jal | ex_jalr);

  always_comb begin
    br_count_d = br_count_q;
    br_taken_d = br_taken_q;
    if (load && is_ctl) begin
      br_count_d = br_count_q + 32'd1;
      if (redirect_d) br_taken_d = br_taken_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q <= '0;
      br_taken_q <= '0;
    end else begin
      br_count_q <= br_count_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign br_count       = br_count_q;
  assign br_taken_count = br_taken_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; the statistics section is
// compiled only when EXMEM_BR_STATS_EN is defined.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst, stall, flush;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_alu_result, ex_rs2_data;
  logic        ex_cf, ex_zf, ex_vf, ex_sf;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_branch, ex_jal, ex_jalr;
  logic [2:0]  ex_funct3;
  logic        mem_valid;
  logic [31:0] mem_alu_result, mem_rs2_data;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic        redirect;
  logic [31:0] redirect_target;
`ifdef EXMEM_BR_STATS_EN
  logic [31:0] br_count, br_taken_count;
`endif

  int checks = 0;
  int errors = 0;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_alu_result(ex_alu_result),
    .ex_cf(ex_cf), .ex_zf(ex_zf), .ex_vf(ex_vf), .ex_sf(ex_sf),
    .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_funct3(ex_funct3),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_rs2_data(mem_rs2_data), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
    .redirect(redirect), .redirect_target(redirect_target)
`ifdef EXMEM_BR_STATS_EN
    ,
    .br_count(br_count), .br_taken_count(br_taken_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    stall = 0; flush = 0; ex_valid = 0;
    ex_pc = 0; ex_imm = 0; ex_alu_result = 0; ex_rs2_data = 0;
    {ex_cf, ex_zf, ex_vf, ex_sf} = 4'b0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
    ex_branch = 0; ex_jal = 0; ex_jalr = 0; ex_funct3 = 0;
  endtask

  task automatic drive_br(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                          input logic cf, input logic zf, input logic vf, input logic sf);
    set_idle();
    ex_valid = 1; ex_branch = 1; ex_pc = pc; ex_imm = imm; ex_funct3 = f3;
    ex_cf = cf; ex_zf = zf; ex_vf = vf; ex_sf = sf;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".valid"}, {31'b0, mem_valid}, 32'd0);
    check({tag, ".result"}, mem_alu_result, 32'd0);
    check({tag, ".rs2"}, mem_rs2_data, 32'd0);
    check({tag, ".rd"}, {27'b0, mem_rd}, 32'd0);
    check({tag, ".ctrl"}, {28'b0, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}, 32'd0);
    check({tag, ".redirect"}, {31'b0, redirect}, 32'd0);
    check({tag, ".target"}, redirect_target, 32'd0);
  endtask

  initial begin
    set_idle();
    rst = 1;
    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      ex_valid = 1'($urandom_range(0, 1)); ex_pc = $urandom; ex_imm = $urandom;
      ex_alu_result = $urandom; ex_rs2_data = $urandom; ex_rd = 5'($urandom_range(0, 31));
      ex_reg_write = 1; ex_mem_write = 1; ex_jal = 1; stall = 1'($urandom_range(0, 1));
      step();
    end
    check_zero_outputs("reset");

    // first ADD after reset
    rst = 0; set_idle();
    ex_valid = 1; ex_alu_result = 32'h0000_0010; ex_rd = 5; ex_reg_write = 1; ex_rs2_data = 32'h55;
    step();
    check("add.valid", {31'b0, mem_valid}, 32'd1);
    check("add.result", mem_alu_result, 32'h10);
    check("add.rd", {27'b0, mem_rd}, 32'd5);
    check("add.reg_write", {31'b0, mem_reg_write}, 32'd1);
    check("add.rs2", mem_rs2_data, 32'h55);
    check("add.redirect", {31'b0, redirect}, 32'd0);

    // load instruction controls
    set_idle();
    ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_mem_to_reg = 1; ex_rd = 9;
    step();
    check("ld.ctrl", {28'b0, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}, 32'b1101);

    // BEQ taken then single-cycle pulse
    drive_br(32'h100, 32'h20, 3'b000, 0, 1, 0, 0);
    step();
    check("beq_t.redirect", {31'b0, redirect}, 32'd1);
    check("beq_t.target", redirect_target, 32'h120);
    check("beq_t.reg_write", {31'b0, mem_reg_write}, 32'd0);
    set_idle();
    step();
    check("beq_t.pulse_end", {31'b0, redirect}, 32'd0);
    check("idle.valid", {31'b0, mem_valid}, 32'd0);
    drive_br(32'h100, 32'h20, 3'b000, 0, 0, 0, 0);
    step();
    check("beq_nt.redirect", {31'b0, redirect}, 32'd0);
    check("beq_nt.valid", {31'b0, mem_valid}, 32'd1);

    // other conditions
    drive_br(32'h200, 32'hFFFF_FFF0, 3'b100, 0, 0, 0, 1);
    step();
    check("blt_t.redirect", {31'b0, redirect}, 32'd1);
    check("blt_t.target", redirect_target, 32'h1F0);
    drive_br(32'h200, 32'h8, 3'b111, 0, 0, 0, 0);
    step();
    check("bgeu_nt.redirect", {31'b0, redirect}, 32'd0);
    drive_br(32'h200, 32'h8, 3'b010, 1, 1, 1, 1);
    step();
    check("f3_010.redirect", {31'b0, redirect}, 32'd0);
    drive_br(32'h200, 32'h8, 3'b011, 0, 0, 1, 0);
    step();
    check("f3_011.redirect", {31'b0, redirect}, 32'd0);
    drive_br(32'h10, 32'h4, 3'b001, 0, 0, 0, 0);
    step();
    check("bne_t.redirect", {31'b0, redirect}, 32'd1);
    check("bne_t.target", redirect_target, 32'h14);
    drive_br(32'h10, 32'h4, 3'b101, 0, 0, 1, 1);
    step();
    check("bge_t.redirect", {31'b0, redirect}, 32'd1);
    drive_br(32'h10, 32'h4, 3'b101, 0, 0, 0, 1);
    step();
    check("bge_nt.redirect", {31'b0, redirect}, 32'd0);
    drive_br(32'h10, 32'h4, 3'b110, 0, 0, 0, 0);
    step();
    check("bltu_t.redirect", {31'b0, redirect}, 32'd1);
    drive_br(32'h10, 32'h4, 3'b110, 1, 0, 0, 0);
    step();
    check("bltu_nt.redirect", {31'b0, redirect}, 32'd0);
    drive_br(32'h10, 32'h4, 3'b000, 0, 1, 0, 0);
    ex_valid = 0;
    step();
    check("br_invalid.redirect", {31'b0, redirect}, 32'd0);

    // JALR
    set_idle();
    ex_valid = 1; ex_jalr = 1; ex_pc = 32'h40; ex_alu_result = 32'h2003; ex_reg_write = 1; ex_rd = 1;
    step();
    check("jalr.redirect", {31'b0, redirect}, 32'd1);
    check("jalr.target", redirect_target, 32'h2002);
    check("jalr.link", mem_alu_result, 32'h44);
    set_idle();
    step();
    check("jalr.pulse_end", {31'b0, redirect}, 32'd0);

    // JAL with PC wrap-around
    set_idle();
    ex_valid = 1; ex_jal = 1; ex_pc = 32'hFFFF_FFFC; ex_imm = 32'h8; ex_reg_write = 1;
    step();
    check("jal_wrap.target", redirect_target, 32'h4);
    check("jal_wrap.link", mem_alu_result, 32'h0);
    check("jal_wrap.redirect", {31'b0, redirect}, 32'd1);

    // jalr wins over jal and branch
    set_idle();
    ex_valid = 1; ex_jalr = 1; ex_jal = 1; ex_branch = 1; ex_zf = 1;
    ex_pc = 32'h80; ex_imm = 32'h100; ex_alu_result = 32'h3001;
    step();
    check("prio_jalr.target", redirect_target, 32'h3000);
    // jal wins over a not-taken branch
    set_idle();
    ex_valid = 1; ex_jal = 1; ex_branch = 1; ex_pc = 32'h80; ex_imm = 32'h100;
    step();
    check("prio_jal.redirect", {31'b0, redirect}, 32'd1);
    check("prio_jal.target", redirect_target, 32'h180);

    // taken branch then stall hold
    drive_br(32'h300, 32'h10, 3'b000, 0, 1, 0, 0);
    ex_alu_result = 32'h77; ex_rs2_data = 32'hABCD; ex_rd = 7; ex_mem_write = 1;
    step();
    check("stall_pre.redirect", {31'b0, redirect}, 32'd1);
    set_idle();
    stall = 1; ex_valid = 1; ex_alu_result = 32'h999; ex_rd = 3; ex_reg_write = 1; ex_jal = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.redirect", {31'b0, redirect}, 32'd0);
      check("stall.valid", {31'b0, mem_valid}, 32'd1);
      check("stall.result", mem_alu_result, 32'h77);
      check("stall.rs2", mem_rs2_data, 32'hABCD);
      check("stall.rd", {27'b0, mem_rd}, 32'd7);
      check("stall.mem_write", {31'b0, mem_mem_write}, 32'd1);
      check("stall.target", redirect_target, 32'h310);
    end
    flush = 1;
    step();
    check("stall_flush.valid", {31'b0, mem_valid}, 32'd0);
    check("stall_flush.ctrl", {28'b0, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}, 32'd0);
    check("stall_flush.redirect", {31'b0, redirect}, 32'd0);

    // flush alone against a taken jump
    set_idle();
    flush = 1; ex_valid = 1; ex_jal = 1; ex_reg_write = 1; ex_mem_read = 1;
    step();
    check("flush.valid", {31'b0, mem_valid}, 32'd0);
    check("flush.redirect", {31'b0, redirect}, 32'd0);
    check("flush.ctrl", {28'b0, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}, 32'd0);

`ifdef EXMEM_BR_STATS_EN
    set_idle();
    rst = 1;
    step();
    rst = 0;
    check("stats.reset", br_count, 32'd0);
    drive_br(32'h0, 32'h4, 3'b000, 0, 1, 0, 0); step();
    drive_br(32'h0, 32'h4, 3'b000, 0, 0, 0, 0); step();
    set_idle(); ex_valid = 1; ex_jal = 1; step();
    drive_br(32'h0, 32'h4, 3'b001, 0, 1, 0, 0); step();
    drive_br(32'h0, 32'h4, 3'b000, 0, 1, 0, 0); flush = 1; step();
    drive_br(32'h0, 32'h4, 3'b000, 0, 1, 0, 0); stall = 1; step();
    set_idle(); step();
    check("stats.br_count", br_count, 32'd4);
    check("stats.br_taken_count", br_taken_count, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
